// File: rtl/alu_status_register_if.sv
// Handshake bundle for the ALU status stage: upstream result/flag inputs and
// the held entry, flags and condition outcome presented downstream.
interface alu_status_register_if #(
  parameter int WIDTH = 4,
  parameter int CNT_W = 8
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] result;
  logic             carry;
  logic             overflow;
  logic [3:0]       flag_we;
  logic [3:0]       cond;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] data_out;
  logic             flag_n;
  logic             flag_z;
  logic             flag_c;
  logic             flag_v;
  logic             cond_true;
  logic [CNT_W-1:0] zero_count;

  modport master (
    output in_valid, result, carry, overflow, flag_we, cond, out_ready,
    input  in_ready, out_valid, data_out, flag_n, flag_z, flag_c, flag_v,
           cond_true, zero_count
  );

  modport slave (
    input  in_valid, result, carry, overflow, flag_we, cond, out_ready,
    output in_ready, out_valid, data_out, flag_n, flag_z, flag_c, flag_v,
           cond_true, zero_count
  );
endinterface

// File: rtl/alu_status_register.sv
// One-entry registered status stage: holds the ALU result, N/Z/C/V flags with
// per-flag write enables, an evaluated condition code and a saturating zero count.
module alu_status_register #(
  parameter int WIDTH = 4,
  parameter int CNT_W = 8
) (
  input logic                  clk,
  input logic                  rst_n,
  alu_status_register_if.slave bus
);

  typedef enum logic {EMPTY, FULL} state_t;

  state_t           state_q, state_next;
  logic [WIDTH-1:0] data_q;
  logic             n_q, z_q, c_q, v_q;
  logic             n_next, z_next, c_next, v_next;
  logic             cond_q;
  logic [CNT_W-1:0] count_q;
  logic             accept;
  logic             z_new;

  // Condition is judged against the flags as they will be after this accept.
  function automatic logic eval_cond(input logic [3:0] c, input logic n,
                                     input logic z, input logic cy, input logic v);
    logic r;
    r = 1'b0;
    case (c)
      4'd0:    r = z;
      4'd1:    r = !z;
      4'd2:    r = cy;
      4'd3:    r = !cy;
      4'd4:    r = n;
      4'd5:    r = !n;
      4'd6:    r = v;
      4'd7:    r = !v;
      4'd8:    r = cy && !z;
      4'd9:    r = !cy || z;
      4'd10:   r = (n == v);
      4'd11:   r = (n != v);
      4'd12:   r = !z && (n == v);
      4'd13:   r = z || (n != v);
      4'd14:   r = 1'b1;
      default: r = 1'b0;
    endcase
    return r;
  endfunction

  assign bus.in_ready = (state_q == EMPTY) || bus.out_ready;
  assign accept       = bus.in_valid && bus.in_ready;
  assign z_new        = (bus.result == '0);

  always_comb begin
    n_next = bus.flag_we[3] ? bus.result[WIDTH-1] : n_q;
    z_next = bus.flag_we[2] ? z_new               : z_q;
    c_next = bus.flag_we[1] ? bus.carry           : c_q;
    v_next = bus.flag_we[0] ? bus.overflow        : v_q;
  end

  always_comb begin
    state_next = state_q;
    case (state_q)
      EMPTY:   if (accept) state_next = FULL;
      FULL:    if (bus.out_ready && !accept) state_next = EMPTY;
      default: state_next = EMPTY;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= EMPTY;
    end else begin
      state_q <= state_next;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      data_q <= '0;
      n_q    <= 1'b0;
      z_q    <= 1'b0;
      c_q    <= 1'b0;
      v_q    <= 1'b0;
      cond_q <= 1'b0;
    end else if (accept) begin
      data_q <= bus.result;
      n_q    <= n_next;
      z_q    <= z_next;
      c_q    <= c_next;
      v_q    <= v_next;
      cond_q <= eval_cond(bus.cond, n_next, z_next, c_next, v_next);
    end
  end

  // Counts every zero result accepted, independent of the Z write enable.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_q <= '0;
    end else if (accept && z_new && (count_q != {CNT_W{1'b1}})) begin
      count_q <= count_q + 1'b1;
    end
  end

  assign bus.out_valid  = (state_q == FULL);
  assign bus.data_out   = data_q;
  assign bus.flag_n     = n_q;
  assign bus.flag_z     = z_q;
  assign bus.flag_c     = c_q;
  assign bus.flag_v     = v_q;
  assign bus.cond_true  = cond_q;
  assign bus.zero_count = count_q;

endmodule

// File: tb/tb_alu_status_register.sv
// Directed bench for alu_status_register with hand-computed expectations;
// a 2-bit zero counter makes saturation reachable in a few pushes.
module tb_alu_status_register;

  localparam int WIDTH = 4;
  localparam int CNT_W = 2;

  logic clk;
  logic rst_n;
  int   checks;
  int   errors;

  alu_status_register_if #(.WIDTH(WIDTH), .CNT_W(CNT_W)) bus ();

  alu_status_register #(.WIDTH(WIDTH), .CNT_W(CNT_W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] actual,
                             input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %0h, expected %0h", tag, actual, expected);
    end
  endtask

  // Presents one result with out_ready=1 and returns 1 time unit after the accepting edge.
  task automatic applyStimulus(input logic [WIDTH-1:0] res, input logic cy,
                               input logic ov, input logic [3:0] we,
                               input logic [3:0] cc);
    @(negedge clk);
    bus.result    = res;
    bus.carry     = cy;
    bus.overflow  = ov;
    bus.flag_we   = we;
    bus.cond      = cc;
    bus.in_valid  = 1'b1;
    bus.out_ready = 1'b1;
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
  endtask

  task automatic checkFlags(input string tag, input logic n, input logic z,
                            input logic c, input logic v);
    checkOutput({tag, "_nzcv"}, {28'd0, bus.flag_n, bus.flag_z, bus.flag_c, bus.flag_v},
                {28'd0, n, z, c, v});
  endtask

  initial begin
    checks        = 0;
    errors        = 0;
    rst_n         = 1'b0;
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b0;
    bus.result    = '0;
    bus.carry     = 1'b0;
    bus.overflow  = 1'b0;
    bus.flag_we   = 4'b0000;
    bus.cond      = 4'd0;

    // Reset state
    repeat (2) @(posedge clk);
    #1;
    checkOutput("rst_in_ready", bus.in_ready, 1);
    checkOutput("rst_out_valid", bus.out_valid, 0);
    checkOutput("rst_data", bus.data_out, 0);
    checkFlags("rst", 0, 0, 0, 0);
    checkOutput("rst_cond", bus.cond_true, 0);
    checkOutput("rst_count", bus.zero_count, 0);
    @(negedge clk);
    rst_n = 1'b1;

    // Single accept: 10 = 4'b1010
    applyStimulus(4'd10, 0, 0, 4'b1111, 4'd1);
    checkOutput("t1_data", bus.data_out, 10);
    checkFlags("t1", 1, 0, 0, 0);
    checkOutput("t1_cond", bus.cond_true, 1);
    checkOutput("t1_valid", bus.out_valid, 1);
    checkOutput("t1_count", bus.zero_count, 0);

    // Zero detection with EQ
    applyStimulus(4'd0, 1, 0, 4'b1111, 4'd0);
    checkFlags("t2", 0, 1, 1, 0);
    checkOutput("t2_cond", bus.cond_true, 1);
    checkOutput("t2_count", bus.zero_count, 1);
    applyStimulus(4'd1, 0, 0, 4'b1111, 4'd1);
    checkFlags("t2_1", 0, 0, 0, 0);
    checkOutput("t2_1_count", bus.zero_count, 1);
    applyStimulus(4'd2, 0, 0, 4'b1111, 4'd0);
    checkOutput("t2_2_cond", bus.cond_true, 0);
    checkOutput("t2_2_count", bus.zero_count, 1);
    applyStimulus(4'd9, 0, 0, 4'b1111, 4'd1);
    checkFlags("t2_9", 1, 0, 0, 0);
    checkOutput("t2_9_count", bus.zero_count, 1);

    // Masked write: Z held at 1 while N/C/V load
    applyStimulus(4'd0, 0, 0, 4'b1111, 4'd0);
    checkOutput("t3_count0", bus.zero_count, 2);
    applyStimulus(4'd5, 1, 1, 4'b1011, 4'd0);
    checkFlags("t3_mask", 0, 1, 1, 1);
    checkOutput("t3_mask_cond", bus.cond_true, 1);
    checkOutput("t3_mask_data", bus.data_out, 5);
    applyStimulus(4'd0, 0, 0, 4'b0000, 4'd9);
    checkFlags("t3_we0", 0, 1, 1, 1);
    checkOutput("t3_we0_cond", bus.cond_true, 1);
    checkOutput("t3_we0_count", bus.zero_count, 3);

    // Backpressure: drain, fill, hold, then simultaneous pop+accept
    @(negedge clk);
    bus.out_ready = 1'b1;
    @(posedge clk);
    #1;
    checkOutput("t4_drained", bus.out_valid, 0);
    applyStimulus(4'd3, 0, 0, 4'b1111, 4'd1);
    checkOutput("t4_fill_data", bus.data_out, 3);
    checkOutput("t4_fill_cond", bus.cond_true, 1);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      bus.result    = WIDTH'(12 + i);
      bus.flag_we   = 4'b1111;
      bus.carry     = 1'b1;
      bus.cond      = 4'd0;
      bus.in_valid  = 1'b1;
      bus.out_ready = 1'b0;
      #1;
      checkOutput("t4_hold_ready", bus.in_ready, 0);
      @(posedge clk);
      #1;
      checkOutput("t4_hold_valid", bus.out_valid, 1);
      checkOutput("t4_hold_data", bus.data_out, 3);
      checkFlags("t4_hold", 0, 0, 0, 0);
      checkOutput("t4_hold_cond", bus.cond_true, 1);
    end
    @(negedge clk);
    bus.result    = 4'd7;
    bus.carry     = 1'b0;
    bus.out_ready = 1'b1;
    #1;
    checkOutput("t4_pass_ready", bus.in_ready, 1);
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
    checkOutput("t4_pass_data", bus.data_out, 7);
    checkOutput("t4_pass_valid", bus.out_valid, 1);
    checkOutput("t4_pass_cond", bus.cond_true, 0);

    // Signed conditions
    applyStimulus(4'd8, 0, 0, 4'b1111, 4'd11);
    checkOutput("t5_lt", bus.cond_true, 1);
    applyStimulus(4'd8, 0, 1, 4'b1111, 4'd12);
    checkOutput("t5_gt", bus.cond_true, 1);
    applyStimulus(4'd8, 0, 0, 4'b1111, 4'd10);
    checkOutput("t5_ge", bus.cond_true, 0);
    applyStimulus(4'd8, 1, 0, 4'b1111, 4'd8);
    checkOutput("t5_hi", bus.cond_true, 1);
    applyStimulus(4'd8, 0, 0, 4'b1111, 4'd15);
    checkOutput("t5_nv", bus.cond_true, 0);

    // Saturation from a fresh reset
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 5; i++) begin
      applyStimulus(4'd0, 1, 0, 4'b1111, 4'd14);
      checkOutput("t6_count", bus.zero_count, (i < 3) ? i + 1 : 3);
    end

    // Asynchronous reset between edges
    #2;
    rst_n = 1'b0;
    #1;
    checkOutput("t6_ar_valid", bus.out_valid, 0);
    checkOutput("t6_ar_ready", bus.in_ready, 1);
    checkFlags("t6_ar", 0, 0, 0, 0);
    checkOutput("t6_ar_cond", bus.cond_true, 0);
    checkOutput("t6_ar_count", bus.zero_count, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
